// File: rtl/exe_stage_md_if.sv
// exe_stage_md_if: ID/EXE-side bundle for the execute stage.
//   master : pipeline side (drives instruction fields, operands, forwards;
//            receives aluout, writedata, regaddr, stall, md_busy)
//   slave  : execute stage (exe_stage_md)
interface exe_stage_md_if #(
  parameter int WIDTH   = 32,
  parameter int RADDR_W = 5
);
  logic               valid_in;
  logic               alusrc;
  logic               regdst;
  logic [3:0]         alucontrol;
  logic [2:0]         mdop;
  logic [WIDTH-1:0]   data1;
  logic [WIDTH-1:0]   data2;
  logic [RADDR_W-1:0] rt;
  logic [RADDR_W-1:0] rd;
  logic [4:0]         shamt;
  logic [WIDTH-1:0]   signext;
  logic [1:0]         forwardA;
  logic [1:0]         forwardB;
  logic [WIDTH-1:0]   aluout_mem;
  logic [WIDTH-1:0]   result_wb;
  logic [WIDTH-1:0]   aluout;
  logic [WIDTH-1:0]   writedata;
  logic [RADDR_W-1:0] regaddr;
  logic               stall;
  logic               md_busy;

  modport master (
    output valid_in, alusrc, regdst, alucontrol, mdop, data1, data2, rt, rd,
           shamt, signext, forwardA, forwardB, aluout_mem, result_wb,
    input  aluout, writedata, regaddr, stall, md_busy
  );

  modport slave (
    input  valid_in, alusrc, regdst, alucontrol, mdop, data1, data2, rt, rd,
           shamt, signext, forwardA, forwardB, aluout_mem, result_wb,
    output aluout, writedata, regaddr, stall, md_busy
  );
endinterface

// File: rtl/exe_stage_md.sv
// exe_stage_md: MIPS execute stage with single-cycle ALU path and an
// iterative (radix-2) multiply/divide unit owning the HI/LO registers.
// Ports:
//   clk     : rising-edge clock
//   rst_n   : asynchronous active-low reset
//   exe_if  : slave side of exe_stage_md_if (operands, forwarding selects,
//             ALU/MD controls in; aluout, writedata, regaddr, stall, md_busy out)
// ALU codes: 0 AND, 1 OR, 2 ADD, 3 XOR, 4 NOR, 5 SLL, 6 SUB, 7 SLT,
//            8 SRL, 9 SRA, 10 SLTU, 11 LUI; others give 0.
// mdop: 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MFHI, 6 MFLO, 0/7 none.
module exe_stage_md #(
  parameter int WIDTH   = 32,
  parameter int RADDR_W = 5,
  parameter int CNT_W   = 6
) (
  input  logic          clk,
  input  logic          rst_n,
  exe_stage_md_if.slave exe_if
);
  localparam logic [3:0] ALU_AND = 4'd0, ALU_OR  = 4'd1, ALU_ADD  = 4'd2,
                         ALU_XOR = 4'd3, ALU_NOR = 4'd4, ALU_SLL  = 4'd5,
                         ALU_SUB = 4'd6, ALU_SLT = 4'd7, ALU_SRL  = 4'd8,
                         ALU_SRA = 4'd9, ALU_SLTU = 4'd10, ALU_LUI = 4'd11;
  localparam logic [2:0] MD_MULT = 3'd1, MD_MULTU = 3'd2, MD_DIV = 3'd3,
                         MD_DIVU = 3'd4, MD_MFHI  = 3'd5, MD_MFLO = 3'd6;

  typedef enum logic {ST_IDLE, ST_BUSY} md_state_e;

  function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] v, input logic neg);
    return neg ? -v : v;
  endfunction

  function automatic logic [2*WIDTH-1:0] cond_neg2(input logic [2*WIDTH-1:0] v, input logic neg);
    return neg ? -v : v;
  endfunction

  // Operand forwarding and ALU
  logic [WIDTH-1:0]        opa, opb, alu_b, alu_res;
  logic signed [WIDTH-1:0] opa_s, alu_b_s;

  always_comb begin
    case (exe_if.forwardA)
      2'd0:    opa = exe_if.data1;
      2'd1:    opa = exe_if.result_wb;
      2'd2:    opa = exe_if.aluout_mem;
      default: opa = '0;
    endcase
    case (exe_if.forwardB)
      2'd0:    opb = exe_if.data2;
      2'd1:    opb = exe_if.result_wb;
      2'd2:    opb = exe_if.aluout_mem;
      default: opb = '0;
    endcase
  end

  assign alu_b   = exe_if.alusrc ? exe_if.signext : opb;
  assign opa_s   = opa;
  assign alu_b_s = alu_b;

  always_comb begin
    case (exe_if.alucontrol)
      ALU_AND:  alu_res = opa & alu_b;
      ALU_OR:   alu_res = opa | alu_b;
      ALU_ADD:  alu_res = opa + alu_b;
      ALU_XOR:  alu_res = opa ^ alu_b;
      ALU_NOR:  alu_res = ~(opa | alu_b);
      ALU_SLL:  alu_res = alu_b << exe_if.shamt;
      ALU_SUB:  alu_res = opa - alu_b;
      ALU_SLT:  alu_res = WIDTH'(opa_s < alu_b_s);
      ALU_SRL:  alu_res = alu_b >> exe_if.shamt;
      ALU_SRA:  alu_res = alu_b_s >>> exe_if.shamt;
      ALU_SLTU: alu_res = WIDTH'(opa < alu_b);
      ALU_LUI:  alu_res = alu_b << (WIDTH / 2);
      default:  alu_res = '0;
    endcase
  end

  // Multiply/divide control
  md_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
  logic [WIDTH-1:0] acc_hi_q, acc_hi_d, acc_lo_q, acc_lo_d, opnd_b_q, opnd_b_d;
  logic             is_div_q, is_div_d, neg_res_q, neg_res_d, neg_rem_q, neg_rem_d;
  logic             div0_q, div0_d;
  logic             md_start_op, md_hilo_op, md_signed, a_neg, b_neg, start, md_busy, stall;

  assign md_start_op = (exe_if.mdop == MD_MULT) || (exe_if.mdop == MD_MULTU) ||
                       (exe_if.mdop == MD_DIV)  || (exe_if.mdop == MD_DIVU);
  assign md_hilo_op  = md_start_op || (exe_if.mdop == MD_MFHI) || (exe_if.mdop == MD_MFLO);
  assign md_signed   = (exe_if.mdop == MD_MULT) || (exe_if.mdop == MD_DIV);
  assign a_neg       = md_signed & opa[WIDTH-1];
  assign b_neg       = md_signed & opb[WIDTH-1];
  assign md_busy     = (state_q == ST_BUSY);
  assign stall       = exe_if.valid_in & md_busy & md_hilo_op;
  assign start       = exe_if.valid_in & md_start_op & ~stall & (state_q == ST_IDLE);

  // One radix-2 step. Multiply keeps the multiplier in acc_lo and shifts the
  // partial product in from the top; divide keeps the dividend in acc_lo and
  // shifts quotient bits in from the bottom while acc_hi holds the remainder.
  logic [WIDTH:0]     mul_sum, div_shift, div_diff;
  logic [WIDTH-1:0]   step_hi, step_lo;
  logic [2*WIDTH-1:0] prod;

  always_comb begin
    mul_sum   = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opnd_b_q} : '0);
    div_shift = {acc_hi_q, acc_lo_q[WIDTH-1]};
    div_diff  = div_shift - {1'b0, opnd_b_q};
    if (is_div_q) begin
      if (!div_diff[WIDTH]) begin
        step_hi = div_diff[WIDTH-1:0];
        step_lo = {acc_lo_q[WIDTH-2:0], 1'b1};
      end else begin
        step_hi = div_shift[WIDTH-1:0];
        step_lo = {acc_lo_q[WIDTH-2:0], 1'b0};
      end
    end else begin
      step_hi = mul_sum[WIDTH:1];
      step_lo = {mul_sum[0], acc_lo_q[WIDTH-1:1]};
    end
    prod = cond_neg2({step_hi, step_lo}, neg_res_q);
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    acc_hi_d  = acc_hi_q;
    acc_lo_d  = acc_lo_q;
    opnd_b_d  = opnd_b_q;
    is_div_d  = is_div_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    div0_d    = div0_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d   = ST_BUSY;
          cnt_d     = CNT_W'(WIDTH - 1);
          acc_hi_d  = '0;
          acc_lo_d  = cond_neg(opa, a_neg);
          opnd_b_d  = cond_neg(opb, b_neg);
          is_div_d  = (exe_if.mdop == MD_DIV) || (exe_if.mdop == MD_DIVU);
          neg_res_d = a_neg ^ b_neg;
          neg_rem_d = a_neg;
          div0_d    = (opb == '0);
        end
      end
      ST_BUSY: begin
        acc_hi_d = step_hi;
        acc_lo_d = step_lo;
        cnt_d    = cnt_q - CNT_W'(1);
        if (cnt_q == '0) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          if (is_div_q) begin
            // Divide by zero leaves |dividend| in the remainder, so only the
            // quotient needs overriding. MIN/-1 falls out of the magnitude path.
            lo_d = div0_q ? '1 : cond_neg(step_lo, neg_res_q);
            hi_d = cond_neg(step_hi, neg_rem_q);
          end else begin
            hi_d = prod[2*WIDTH-1:WIDTH];
            lo_d = prod[WIDTH-1:0];
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  always_ff @(posedge clk) begin
    acc_hi_q  <= acc_hi_d;
    acc_lo_q  <= acc_lo_d;
    opnd_b_q  <= opnd_b_d;
    is_div_q  <= is_div_d;
    neg_res_q <= neg_res_d;
    neg_rem_q <= neg_rem_d;
    div0_q    <= div0_d;
  end

  // Outputs
  assign exe_if.aluout    = (exe_if.mdop == MD_MFHI) ? hi_q :
                            (exe_if.mdop == MD_MFLO) ? lo_q : alu_res;
  assign exe_if.writedata = opb;
  assign exe_if.regaddr   = exe_if.regdst ? exe_if.rd : exe_if.rt;
  assign exe_if.stall     = stall;
  assign exe_if.md_busy   = md_busy;
endmodule

// File: tb/tb_exe_stage_md.sv
// tb_exe_stage_md: self-checking bench for exe_stage_md. Multiply/divide
// results are predicted by a behavioural model, queued at issue and compared
// when the bench reads HI/LO back through MFHI/MFLO.
`timescale 1ns/1ps
module tb_exe_stage_md;
  localparam int W = 32;
  localparam logic [3:0] ALU_ADD = 4'd2, ALU_SUB = 4'd6, ALU_SLT = 4'd7,
                         ALU_SRA = 4'd9, ALU_SLTU = 4'd10;
  localparam logic [2:0] MD_MULT = 3'd1, MD_MULTU = 3'd2, MD_DIV = 3'd3,
                         MD_DIVU = 3'd4, MD_MFHI = 3'd5, MD_MFLO = 3'd6;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  exe_stage_md_if #(.WIDTH(W), .RADDR_W(5)) bus ();
  exe_stage_md #(.WIDTH(W), .RADDR_W(5), .CNT_W(6)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .exe_if(bus)
  );

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [63:0] exp_q[$];

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] want);
    n_tests++;
    if (obs !== want) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, want);
    end
  endtask

  function automatic logic [63:0] md_model(input logic [2:0] op, input logic [31:0] a,
                                           input logic [31:0] b);
    longint      sa, sb, q, r;
    logic [63:0] ua, ub;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    md_model = '0;
    case (op)
      MD_MULT:  md_model = 64'(sa * sb);
      MD_MULTU: md_model = ua * ub;
      MD_DIV: begin
        if (b == 32'd0) md_model = {a, 32'hFFFF_FFFF};
        else begin
          q = sa / sb;
          r = sa % sb;
          md_model = {r[31:0], q[31:0]};
        end
      end
      MD_DIVU: begin
        if (b == 32'd0) md_model = {a, 32'hFFFF_FFFF};
        else md_model = {32'(ua % ub), 32'(ua / ub)};
      end
      default: md_model = '0;
    endcase
  endfunction

  task automatic idle_inputs();
    bus.valid_in = 1'b0;  bus.alusrc = 1'b0;   bus.regdst = 1'b0;
    bus.alucontrol = ALU_ADD; bus.mdop = 3'd0;
    bus.data1 = '0;  bus.data2 = '0;  bus.rt = '0;  bus.rd = '0;
    bus.shamt = '0;  bus.signext = '0; bus.forwardA = 2'd0; bus.forwardB = 2'd0;
    bus.aluout_mem = '0; bus.result_wb = '0;
  endtask

  task automatic drive_md(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    idle_inputs();
    bus.valid_in = 1'b1;
    bus.mdop     = op;
    bus.data1    = a;
    bus.data2    = b;
  endtask

  // Pops one expected {HI,LO} and reads both registers back through aluout.
  task automatic read_hilo(input string tag);
    logic [63:0] want;
    check_eq({tag, "_sb_depth"}, 64'(exp_q.size()), 64'd1);
    if (exp_q.size() != 0) begin
      want = exp_q.pop_front();
      bus.valid_in = 1'b1;
      bus.mdop = MD_MFHI; #1;
      check_eq({tag, "_hi"}, {32'd0, bus.aluout}, {32'd0, want[63:32]});
      bus.mdop = MD_MFLO; #1;
      check_eq({tag, "_lo"}, {32'd0, bus.aluout}, {32'd0, want[31:0]});
    end
    idle_inputs();
  endtask

  // Issues one op, then bubbles carrying an MFHI (which must not stall) until done.
  task automatic run_md(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input string tag);
    int   busy_cyc;
    logic stall_seen;
    @(negedge clk);
    drive_md(op, a, b);
    exp_q.push_back(md_model(op, a, b));
    @(negedge clk);
    idle_inputs();
    bus.mdop = MD_MFHI;
    #1;
    busy_cyc   = 0;
    stall_seen = 1'b0;
    while (bus.md_busy && busy_cyc < 100) begin
      busy_cyc++;
      stall_seen |= bus.stall;
      @(negedge clk); #1;
    end
    check_eq({tag, "_busy_cycles"}, 64'(busy_cyc), 64'(W));
    check_eq({tag, "_bubble_stall"}, {63'd0, stall_seen}, 64'd0);
    read_hilo(tag);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int stall_cyc;
    int busy_cyc;
    logic [2:0]  rop;
    logic [31:0] ra, rb;

    rst_n = 1'b0;
    idle_inputs();
    bus.valid_in = 1'b1;
    bus.mdop     = MD_MFHI;
    @(negedge clk); #1;
    check_eq("rst_busy",  {63'd0, bus.md_busy}, 64'd0);
    check_eq("rst_stall", {63'd0, bus.stall},   64'd0);
    check_eq("rst_hi",    {32'd0, bus.aluout},  64'd0);
    bus.mdop = MD_MFLO; #1;
    check_eq("rst_lo",    {32'd0, bus.aluout},  64'd0);
    rst_n = 1'b1;
    idle_inputs();

    // ALU path and forwarding
    @(negedge clk);
    bus.valid_in = 1'b1; bus.data1 = 32'd5; bus.forwardA = 2'd2; bus.aluout_mem = 32'h10;
    bus.alusrc = 1'b1; bus.signext = 32'd3; bus.alucontrol = ALU_ADD; #1;
    check_eq("alu_add_fwd_mem", {32'd0, bus.aluout}, 64'h13);
    bus.forwardB = 2'd1; bus.result_wb = 32'hABCD; bus.data2 = 32'h1111; #1;
    check_eq("wdata_fwd_wb", {32'd0, bus.writedata}, 64'hABCD);
    bus.forwardB = 2'd3; #1;
    check_eq("wdata_fwd_zero", {32'd0, bus.writedata}, 64'h0);
    bus.rt = 5'd4; bus.rd = 5'd9; bus.regdst = 1'b1; #1;
    check_eq("regaddr_rd", {59'd0, bus.regaddr}, 64'd9);
    bus.regdst = 1'b0; #1;
    check_eq("regaddr_rt", {59'd0, bus.regaddr}, 64'd4);
    idle_inputs();
    bus.valid_in = 1'b1; bus.data1 = 32'd3; bus.data2 = 32'd5; bus.alucontrol = ALU_SUB; #1;
    check_eq("alu_sub", {32'd0, bus.aluout}, 64'hFFFF_FFFE);
    bus.data1 = 32'hFFFF_FFFF; bus.data2 = 32'd1; bus.alucontrol = ALU_SLT; #1;
    check_eq("alu_slt", {32'd0, bus.aluout}, 64'd1);
    bus.alucontrol = ALU_SLTU; #1;
    check_eq("alu_sltu", {32'd0, bus.aluout}, 64'd0);
    bus.data2 = 32'h8000_0000; bus.shamt = 5'd4; bus.alucontrol = ALU_SRA; #1;
    check_eq("alu_sra", {32'd0, bus.aluout}, 64'hF800_0000);

    // Bubble carrying MULT and mdop 7 must not start anything
    @(negedge clk);
    drive_md(MD_MULT, 32'd2, 32'd3);
    bus.valid_in = 1'b0;
    @(negedge clk);
    drive_md(3'd7, 32'd2, 32'd3);
    #1;
    check_eq("bubble_no_start", {63'd0, bus.md_busy}, 64'd0);
    @(negedge clk); #1;
    check_eq("mdop7_no_start", {63'd0, bus.md_busy}, 64'd0);

    // MULT -3*7, one unrelated instruction, then MFHI waits for the result
    @(negedge clk);
    drive_md(MD_MULT, 32'hFFFF_FFFD, 32'd7);
    exp_q.push_back(md_model(MD_MULT, 32'hFFFF_FFFD, 32'd7));
    @(negedge clk);
    idle_inputs();
    bus.valid_in = 1'b1; bus.data1 = 32'd1; bus.data2 = 32'd2; #1;
    check_eq("busy_after_start", {63'd0, bus.md_busy}, 64'd1);
    check_eq("add_no_stall",     {63'd0, bus.stall},   64'd0);
    @(negedge clk);
    idle_inputs();
    bus.valid_in = 1'b1; bus.mdop = MD_MFHI; #1;
    stall_cyc = 0;
    while (bus.stall && stall_cyc < 100) begin
      stall_cyc++;
      @(negedge clk); #1;
    end
    check_eq("mfhi_stall_cycles", 64'(stall_cyc), 64'd31);
    check_eq("mfhi_after_busy",   {32'd0, bus.aluout}, 64'hFFFF_FFFF);
    read_hilo("mult_neg");

    // Divides, corner cases and wide multiplies
    run_md(MD_DIVU,  32'd100,        32'd7,         "divu_100_7");
    run_md(MD_DIV,   32'h25,         32'd0,         "div_by_zero");
    run_md(MD_DIV,   32'h8000_0000,  32'hFFFF_FFFF, "div_overflow");
    run_md(MD_DIV,   32'hFFFF_FFF9,  32'd2,         "div_neg_pos");
    run_md(MD_DIV,   32'd7,          32'hFFFF_FFFE, "div_pos_neg");
    run_md(MD_MULTU, 32'hFFFF_FFFF,  32'hFFFF_FFFF, "multu_max");
    run_md(MD_MULT,  32'h8000_0000,  32'h8000_0000, "mult_min");
    run_md(MD_DIVU,  32'hFFFF_FFFF,  32'd0,         "divu_by_zero");

    // Reset in the middle of an operation
    @(negedge clk);
    drive_md(MD_MULT, 32'd123, 32'd456);
    @(negedge clk);
    idle_inputs();
    repeat (9) @(negedge clk);
    bus.valid_in = 1'b1; bus.mdop = MD_MFLO; #1;
    check_eq("pre_rst_stall", {63'd0, bus.stall}, 64'd1);
    #1 rst_n = 1'b0;
    #1;
    check_eq("mid_rst_busy",  {63'd0, bus.md_busy}, 64'd0);
    check_eq("mid_rst_stall", {63'd0, bus.stall},   64'd0);
    rst_n = 1'b1;
    #1;
    check_eq("mid_rst_mflo", {32'd0, bus.aluout}, 64'd0);
    @(negedge clk);
    idle_inputs(); #1;
    check_eq("mid_rst_idle", {63'd0, bus.md_busy}, 64'd0);

    // Back-to-back MULTs: the second stalls, then starts; its operands are
    // captured at its own start and later input changes are ignored. The
    // first product is overwritten before it can be read, so only the
    // second is queued.
    @(negedge clk);
    drive_md(MD_MULT, 32'h1234, 32'h5678);
    @(negedge clk);
    drive_md(MD_MULT, 32'hFFFF_FFFB, 32'h1000);
    #1;
    stall_cyc = 0;
    while (bus.stall && stall_cyc < 100) begin
      stall_cyc++;
      @(negedge clk); #1;
    end
    check_eq("mult2_stall_cycles", 64'(stall_cyc), 64'(W));
    exp_q.push_back(md_model(MD_MULT, 32'hFFFF_FFFB, 32'h1000));
    @(negedge clk);
    idle_inputs();
    bus.data1 = 32'hDEAD_BEEF; bus.data2 = 32'h7777; bus.forwardA = 2'd3; #1;
    busy_cyc = 0;
    while (bus.md_busy && busy_cyc < 100) begin
      busy_cyc++;
      @(negedge clk); #1;
    end
    check_eq("mult2_busy_cycles", 64'(busy_cyc), 64'(W));
    read_hilo("mult2");

    // A few random operations
    for (int i = 0; i < 4; i++) begin
      rop = 3'($urandom_range(1, 4));
      ra  = $urandom;
      rb  = (i == 1) ? 32'($urandom_range(1, 15)) : $urandom;
      run_md(rop, ra, rb, "rand");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
